// File: rtl/acl2_pkg.sv
// rtl/acl2_pkg.sv - state encoding, ADXL362 register map and request field helpers
package acl2_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_ID_RD,
        ST_CFG_WR,
        ST_POLL_WAIT,
        ST_RD_X,
        ST_RD_Y,
        ST_RD_Z,
        ST_ERR_HOLD
    } state_t;

    localparam logic [7:0] CMD_WR    = 8'h0A;
    localparam logic [7:0] CMD_RD    = 8'h0B;
    localparam logic [7:0] DEVID     = 8'h00;
    localparam logic [7:0] XDATA     = 8'h08;
    localparam logic [7:0] YDATA     = 8'h09;
    localparam logic [7:0] ZDATA     = 8'h0A;
    localparam logic [7:0] POWER_CTL = 8'h2D;
    localparam logic [7:0] DEVID_VAL = 8'hAD;
    localparam logic [7:0] MEAS_MODE = 8'h02;

    function automatic logic [7:0] req_cmd(input state_t s);
        return (s == ST_CFG_WR) ? CMD_WR : CMD_RD;
    endfunction

    function automatic logic [7:0] req_addr(input state_t s);
        case (s)
            ST_CFG_WR: return POWER_CTL;
            ST_RD_X:   return XDATA;
            ST_RD_Y:   return YDATA;
            ST_RD_Z:   return ZDATA;
            default:   return DEVID;
        endcase
    endfunction

    function automatic logic [7:0] req_wdata(input state_t s);
        return (s == ST_CFG_WR) ? MEAS_MODE : 8'h00;
    endfunction

endpackage

// File: rtl/txn_timer.sv
// rtl/txn_timer.sv - loadable down-counter that parks at zero and flags it
module txn_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rst_val,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= rst_val;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/acl2_poll_sequencer.sv
// rtl/acl2_poll_sequencer.sv - ADXL362 bring-up and periodic X/Y/Z poll over a byte-transaction SPI engine
module acl2_poll_sequencer
    import acl2_pkg::*;
#(
    parameter int BOOT_WAIT   = 625000,
    parameter int POLL_PERIOD = 1250000,
    parameter int TXN_TIMEOUT = 4096,
    parameter int RETRY_WAIT  = 125000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] DISP_SEL,
    output logic       TXN_REQ,
    output logic       TXN_RW,
    output logic [7:0] TXN_ADDR,
    output logic [7:0] TXN_WDATA,
    input  logic       TXN_DONE,
    input  logic [7:0] TXN_RDATA,
    output logic [7:0] X_DATA,
    output logic [7:0] Y_DATA,
    output logic [7:0] Z_DATA,
    output logic       SAMPLE_VALID,
    output logic [7:0] DATA_OUT,
    output logic       ERROR,
    output logic [3:0] ERR_COUNT
);

    localparam int WAIT_MAX = (BOOT_WAIT > POLL_PERIOD)
        ? ((BOOT_WAIT > RETRY_WAIT) ? BOOT_WAIT : RETRY_WAIT)
        : ((POLL_PERIOD > RETRY_WAIT) ? POLL_PERIOD : RETRY_WAIT);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int TO_W   = $clog2(TXN_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] BOOT_LD   = WAIT_W'(BOOT_WAIT - 1);
    localparam logic [WAIT_W-1:0] PERIOD_LD = WAIT_W'(POLL_PERIOD - 1);
    localparam logic [WAIT_W-1:0] RETRY_LD  = WAIT_W'(RETRY_WAIT - 1);
    localparam logic [TO_W-1:0]   TO_LD     = TO_W'(TXN_TIMEOUT - 1);

    state_t              state;
    state_t              issue_st;
    logic                issue;
    logic                done_ok;
    logic                to_fire;
    logic                bad_id;
    logic                err_event;
    logic                wait_zero;
    logic                to_zero;
    logic                wait_load;
    logic [WAIT_W-1:0]   wait_val;

    // One timer serves boot, poll period and retry; the period keeps running through the burst.
    txn_timer #(.W(WAIT_W)) u_wait_timer (
        .clk      (CLK),
        .rst      (RESET),
        .rst_val  (BOOT_LD),
        .load     (wait_load),
        .load_val (wait_val),
        .en       (1'b1),
        .zero     (wait_zero)
    );

    // Held at TXN_TIMEOUT-1 while idle so the first request cycle starts the full budget.
    txn_timer #(.W(TO_W)) u_req_timer (
        .clk      (CLK),
        .rst      (RESET),
        .rst_val  (TO_LD),
        .load     (!TXN_REQ),
        .load_val (TO_LD),
        .en       (TXN_REQ),
        .zero     (to_zero)
    );

    always_comb begin
        done_ok   = TXN_REQ && TXN_DONE;
        to_fire   = TXN_REQ && !TXN_DONE && to_zero;
        bad_id    = done_ok && (state == ST_ID_RD) && (TXN_RDATA != DEVID_VAL);
        err_event = to_fire || bad_id;
        wait_load = 1'b0;
        wait_val  = PERIOD_LD;
        issue     = 1'b0;
        issue_st  = state;
        if (err_event) begin
            wait_load = 1'b1;
            wait_val  = RETRY_LD;
        end else if (done_ok && (state == ST_CFG_WR || (state == ST_RD_Z && wait_zero))) begin
            wait_load = 1'b1;
        end
        case (state)
            ST_BOOT, ST_ERR_HOLD: begin
                if (wait_zero) begin
                    issue    = 1'b1;
                    issue_st = ST_ID_RD;
                end
            end
            ST_POLL_WAIT: begin
                if (wait_zero) begin
                    issue     = 1'b1;
                    issue_st  = ST_RD_X;
                    wait_load = 1'b1;
                end
            end
            default: begin
                // Request states re-raise only after the one-cycle low gap following DONE.
                if (!TXN_REQ) issue = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_BOOT;
            TXN_REQ      <= 1'b0;
            TXN_RW       <= 1'b0;
            TXN_ADDR     <= 8'h00;
            TXN_WDATA    <= 8'h00;
            X_DATA       <= 8'h00;
            Y_DATA       <= 8'h00;
            Z_DATA       <= 8'h00;
            SAMPLE_VALID <= 1'b0;
            DATA_OUT     <= 8'h00;
            ERROR        <= 1'b0;
            ERR_COUNT    <= 4'h0;
        end else begin
            SAMPLE_VALID <= 1'b0;
            case (DISP_SEL)
                2'd0: DATA_OUT <= X_DATA;
                2'd1: DATA_OUT <= Y_DATA;
                2'd2: DATA_OUT <= Z_DATA;
                2'd3: DATA_OUT <= {ERROR, 3'b000, ERR_COUNT};
            endcase
            if (issue) begin
                state     <= issue_st;
                TXN_REQ   <= 1'b1;
                TXN_RW    <= (req_cmd(issue_st) == CMD_RD);
                TXN_ADDR  <= req_addr(issue_st);
                TXN_WDATA <= req_wdata(issue_st);
                ERROR     <= 1'b0;
            end else if (err_event) begin
                TXN_REQ <= 1'b0;
                state   <= ST_ERR_HOLD;
                ERROR   <= 1'b1;
                if (ERR_COUNT != 4'hF) ERR_COUNT <= ERR_COUNT + 4'd1;
            end else if (done_ok) begin
                TXN_REQ <= 1'b0;
                case (state)
                    ST_ID_RD:  state <= ST_CFG_WR;
                    ST_CFG_WR: state <= ST_POLL_WAIT;
                    ST_RD_X: begin
                        X_DATA <= TXN_RDATA;
                        state  <= ST_RD_Y;
                    end
                    ST_RD_Y: begin
                        Y_DATA <= TXN_RDATA;
                        state  <= ST_RD_Z;
                    end
                    ST_RD_Z: begin
                        Z_DATA       <= TXN_RDATA;
                        SAMPLE_VALID <= 1'b1;
                        state        <= wait_zero ? ST_RD_X : ST_POLL_WAIT;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acl2_poll_sequencer.sv
// tb/tb_acl2_poll_sequencer.sv - directed bench for the ACL2 poll sequencer
module tb_acl2_poll_sequencer;

    localparam int P_BOOT  = 16;
    localparam int P_POLL  = 40;
    localparam int P_TO    = 12;
    localparam int P_RETRY = 10;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] DISP_SEL = 2'd0;
    logic       TXN_REQ;
    logic       TXN_RW;
    logic [7:0] TXN_ADDR;
    logic [7:0] TXN_WDATA;
    logic       TXN_DONE = 1'b0;
    logic [7:0] TXN_RDATA = 8'h00;
    logic [7:0] X_DATA;
    logic [7:0] Y_DATA;
    logic [7:0] Z_DATA;
    logic       SAMPLE_VALID;
    logic [7:0] DATA_OUT;
    logic       ERROR;
    logic [3:0] ERR_COUNT;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int x_cyc = 0;

    acl2_poll_sequencer #(
        .BOOT_WAIT   (P_BOOT),
        .POLL_PERIOD (P_POLL),
        .TXN_TIMEOUT (P_TO),
        .RETRY_WAIT  (P_RETRY)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DISP_SEL     (DISP_SEL),
        .TXN_REQ      (TXN_REQ),
        .TXN_RW       (TXN_RW),
        .TXN_ADDR     (TXN_ADDR),
        .TXN_WDATA    (TXN_WDATA),
        .TXN_DONE     (TXN_DONE),
        .TXN_RDATA    (TXN_RDATA),
        .X_DATA       (X_DATA),
        .Y_DATA       (Y_DATA),
        .Z_DATA       (Z_DATA),
        .SAMPLE_VALID (SAMPLE_VALID),
        .DATA_OUT     (DATA_OUT),
        .ERROR        (ERROR),
        .ERR_COUNT    (ERR_COUNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic wait_req(input int max, output int n, output bit ok);
        n = 0;
        while (TXN_REQ !== 1'b1 && n < max) begin
            @(negedge CLK);
            n++;
        end
        ok = (TXN_REQ === 1'b1);
    endtask

    task automatic respond(input logic [7:0] d, input int lat);
        repeat (lat) @(negedge CLK);
        TXN_DONE  = 1'b1;
        TXN_RDATA = d;
        @(negedge CLK);
        TXN_DONE  = 1'b0;
        TXN_RDATA = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET    = 1'b1;
        TXN_DONE = 1'b0;
        DISP_SEL = 2'd0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        total++;
        if ({TXN_REQ, TXN_RW, TXN_ADDR, TXN_WDATA} !== 18'h0) begin
            bad++;
            $display("FAIL reset_txn got req=%b rw=%b addr=%h wdata=%h want all 0", TXN_REQ, TXN_RW, TXN_ADDR, TXN_WDATA);
        end
        total++;
        if ({X_DATA, Y_DATA, Z_DATA, DATA_OUT} !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got x=%h y=%h z=%h out=%h want 00", X_DATA, Y_DATA, Z_DATA, DATA_OUT);
        end
        total++;
        if ({SAMPLE_VALID, ERROR, ERR_COUNT} !== 6'h0) begin
            bad++;
            $display("FAIL reset_status got sv=%b err=%b cnt=%0d want 0", SAMPLE_VALID, ERROR, ERR_COUNT);
        end
        RESET = 1'b0;
    endtask

    task automatic test_bringup();
        int n;
        bit ok;
        wait_req(100, n, ok);
        total++;
        if (!ok || n != P_BOOT) begin
            bad++;
            $display("FAIL boot_req_cycle got=%0d want=%0d", n + 1, P_BOOT + 1);
        end
        total++;
        if (TXN_RW !== 1'b1 || TXN_ADDR !== 8'h00) begin
            bad++;
            $display("FAIL id_req_fields got rw=%b addr=%h want rw=1 addr=00", TXN_RW, TXN_ADDR);
        end
        repeat (2) begin
            @(negedge CLK);
            total++;
            if (TXN_REQ !== 1'b1 || TXN_RW !== 1'b1 || TXN_ADDR !== 8'h00) begin
                bad++;
                $display("FAIL id_req_hold got req=%b rw=%b addr=%h want 1 1 00", TXN_REQ, TXN_RW, TXN_ADDR);
            end
        end
        respond(8'hAD, 0);
        total++;
        if (TXN_REQ !== 1'b0) begin
            bad++;
            $display("FAIL req_low_after_done got=%b want=0", TXN_REQ);
        end
        wait_req(10, n, ok);
        total++;
        if (!ok || n != 1) begin
            bad++;
            $display("FAIL cfg_req_gap got=%0d want=1", n);
        end
        total++;
        if (TXN_RW !== 1'b0 || TXN_ADDR !== 8'h2D || TXN_WDATA !== 8'h02) begin
            bad++;
            $display("FAIL cfg_fields got rw=%b addr=%h wdata=%h want 0 2d 02", TXN_RW, TXN_ADDR, TXN_WDATA);
        end
        respond(8'h00, 0);
        wait_req(200, n, ok);
        x_cyc = cyc;
        total++;
        if (!ok || n != P_POLL || TXN_ADDR !== 8'h08) begin
            bad++;
            $display("FAIL first_poll got delay=%0d addr=%h want delay=%0d addr=08", n, TXN_ADDR, P_POLL);
        end
    endtask

    task automatic test_poll_burst();
        int n;
        bit ok;
        respond(8'h12, 1);
        wait_req(10, n, ok);
        total++;
        if (!ok || n != 1 || TXN_ADDR !== 8'h09) begin
            bad++;
            $display("FAIL rd_y_req got n=%0d addr=%h want n=1 addr=09", n, TXN_ADDR);
        end
        respond(8'h34, 1);
        wait_req(10, n, ok);
        total++;
        if (!ok || TXN_ADDR !== 8'h0A) begin
            bad++;
            $display("FAIL rd_z_req got ok=%b addr=%h want 0a", ok, TXN_ADDR);
        end
        respond(8'h56, 0);
        total++;
        if (SAMPLE_VALID !== 1'b1 || X_DATA !== 8'h12 || Y_DATA !== 8'h34 || Z_DATA !== 8'h56) begin
            bad++;
            $display("FAIL burst_data got sv=%b x=%h y=%h z=%h want 1 12 34 56", SAMPLE_VALID, X_DATA, Y_DATA, Z_DATA);
        end
        total++;
        if (DATA_OUT !== 8'h12) begin
            bad++;
            $display("FAIL data_out_x got=%h want=12", DATA_OUT);
        end
        DISP_SEL = 2'd1;
        @(negedge CLK);
        total++;
        if (SAMPLE_VALID !== 1'b0 || DATA_OUT !== 8'h34) begin
            bad++;
            $display("FAIL data_out_y got sv=%b out=%h want sv=0 out=34", SAMPLE_VALID, DATA_OUT);
        end
    endtask

    task automatic test_done_while_idle();
        TXN_DONE  = 1'b1;
        TXN_RDATA = 8'hFF;
        @(negedge CLK);
        TXN_DONE  = 1'b0;
        TXN_RDATA = 8'h00;
        @(negedge CLK);
        total++;
        if (TXN_REQ !== 1'b0 || SAMPLE_VALID !== 1'b0 || ERROR !== 1'b0 ||
            X_DATA !== 8'h12 || Y_DATA !== 8'h34 || Z_DATA !== 8'h56) begin
            bad++;
            $display("FAIL stray_done got req=%b sv=%b err=%b x=%h y=%h z=%h want 0 0 0 12 34 56",
                     TXN_REQ, SAMPLE_VALID, ERROR, X_DATA, Y_DATA, Z_DATA);
        end
    endtask

    task automatic test_timeout();
        int n;
        int hi;
        bit ok;
        bit sv_seen;
        wait_req(100, n, ok);
        total++;
        if (!ok || (cyc - x_cyc) != P_POLL || TXN_ADDR !== 8'h08) begin
            bad++;
            $display("FAIL poll_period got=%0d addr=%h want=%0d addr=08", cyc - x_cyc, TXN_ADDR, P_POLL);
        end
        respond(8'h77, 0);
        wait_req(10, n, ok);
        hi = 0;
        sv_seen = 1'b0;
        while (TXN_REQ === 1'b1 && hi < 100) begin
            @(negedge CLK);
            hi++;
            if (SAMPLE_VALID === 1'b1) sv_seen = 1'b1;
        end
        total++;
        if (!ok || hi != P_TO) begin
            bad++;
            $display("FAIL timeout_len got=%0d want=%0d", hi, P_TO);
        end
        total++;
        if (ERROR !== 1'b1 || ERR_COUNT !== 4'd1 || X_DATA !== 8'h77 || Y_DATA !== 8'h34 || Z_DATA !== 8'h56) begin
            bad++;
            $display("FAIL timeout_state got err=%b cnt=%0d x=%h y=%h z=%h want 1 1 77 34 56",
                     ERROR, ERR_COUNT, X_DATA, Y_DATA, Z_DATA);
        end
        DISP_SEL = 2'd3;
        @(negedge CLK);
        if (SAMPLE_VALID === 1'b1) sv_seen = 1'b1;
        total++;
        if (DATA_OUT !== 8'h81 || sv_seen !== 1'b0) begin
            bad++;
            $display("FAIL timeout_status got out=%h sv_seen=%b want out=81 sv_seen=0", DATA_OUT, sv_seen);
        end
    endtask

    task automatic test_done_in_timeout_cycle();
        int n;
        bit ok;
        wait_req(100, n, ok);
        total++;
        if (!ok || n != P_RETRY - 1 || TXN_ADDR !== 8'h00 || ERROR !== 1'b0) begin
            bad++;
            $display("FAIL retry_after_timeout got n=%0d addr=%h err=%b want n=%0d addr=00 err=0", n, TXN_ADDR, ERROR, P_RETRY - 1);
        end
        repeat (P_TO - 1) @(negedge CLK);
        total++;
        if (TXN_REQ !== 1'b1) begin
            bad++;
            $display("FAIL req_before_timeout got=%b want=1", TXN_REQ);
        end
        respond(8'hAD, 0);
        total++;
        if (TXN_REQ !== 1'b0 || ERROR !== 1'b0 || ERR_COUNT !== 4'd1) begin
            bad++;
            $display("FAIL done_at_timeout got req=%b err=%b cnt=%0d want 0 0 1", TXN_REQ, ERROR, ERR_COUNT);
        end
        wait_req(10, n, ok);
        total++;
        if (!ok || n != 1 || TXN_ADDR !== 8'h2D) begin
            bad++;
            $display("FAIL done_at_timeout_next got n=%0d addr=%h want n=1 addr=2d", n, TXN_ADDR);
        end
    endtask

    task automatic test_bad_id();
        int n;
        bit ok;
        do_reset();
        wait_req(100, n, ok);
        respond(8'h00, 0);
        total++;
        if (TXN_REQ !== 1'b0 || ERROR !== 1'b1 || ERR_COUNT !== 4'd1) begin
            bad++;
            $display("FAIL bad_id got req=%b err=%b cnt=%0d want 0 1 1", TXN_REQ, ERROR, ERR_COUNT);
        end
        wait_req(100, n, ok);
        total++;
        if (!ok || n != P_RETRY || TXN_ADDR !== 8'h00 || TXN_RW !== 1'b1 || ERROR !== 1'b0) begin
            bad++;
            $display("FAIL bad_id_retry got n=%0d addr=%h rw=%b err=%b want n=%0d addr=00 rw=1 err=0",
                     n, TXN_ADDR, TXN_RW, ERROR, P_RETRY);
        end
    endtask

    task automatic test_err_saturation();
        int n;
        bit ok;
        int lost;
        lost = 0;
        for (int i = 0; i < 15; i++) begin
            respond(8'h00, 0);
            wait_req(100, n, ok);
            if (!ok) lost++;
        end
        total++;
        if (lost != 0 || ERR_COUNT !== 4'd15) begin
            bad++;
            $display("FAIL err_saturate got cnt=%0d lost=%0d want cnt=15 lost=0", ERR_COUNT, lost);
        end
    endtask

    task automatic test_reset_mid_rdz();
        int n;
        bit ok;
        respond(8'hAD, 0);
        wait_req(10, n, ok);
        respond(8'h00, 0);
        wait_req(200, n, ok);
        respond(8'hA1, 0);
        wait_req(10, n, ok);
        respond(8'hB2, 0);
        wait_req(10, n, ok);
        total++;
        if (!ok || TXN_ADDR !== 8'h0A || X_DATA !== 8'hA1 || ERR_COUNT !== 4'd15) begin
            bad++;
            $display("FAIL pre_reset_rdz got ok=%b addr=%h x=%h cnt=%0d want 1 0a a1 15", ok, TXN_ADDR, X_DATA, ERR_COUNT);
        end
        RESET = 1'b1;
        @(negedge CLK);
        total++;
        if ({TXN_REQ, TXN_RW, TXN_ADDR, TXN_WDATA, X_DATA, Y_DATA, Z_DATA, SAMPLE_VALID, DATA_OUT, ERROR, ERR_COUNT} !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid_rdz got req=%b addr=%h x=%h y=%h out=%h err=%b cnt=%0d want all 0",
                     TXN_REQ, TXN_ADDR, X_DATA, Y_DATA, DATA_OUT, ERROR, ERR_COUNT);
        end
        RESET     = 1'b0;
        TXN_DONE  = 1'b1;
        TXN_RDATA = 8'h99;
        @(negedge CLK);
        TXN_DONE  = 1'b0;
        TXN_RDATA = 8'h00;
        wait_req(100, n, ok);
        total++;
        if (!ok || n != P_BOOT - 1 || TXN_ADDR !== 8'h00 || Z_DATA !== 8'h00 || ERR_COUNT !== 4'd0) begin
            bad++;
            $display("FAIL restart_after_reset got n=%0d addr=%h z=%h cnt=%0d want n=%0d addr=00 z=00 cnt=0",
                     n, TXN_ADDR, Z_DATA, ERR_COUNT, P_BOOT - 1);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_poll_burst();
        test_done_while_idle();
        test_timeout();
        test_done_in_timeout_cycle();
        test_bad_id();
        test_err_saturation();
        test_reset_mid_rdz();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
